// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares one single-cycle SRAM port among several hosts.
// Grants the RAM port every cycle and routes each response to the host granted one cycle earlier.
module ram_port_arbiter #(
  parameter int NumHosts  = 2,
  parameter bit RoundRobin = 1'b1,
  parameter int AddrWidth = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumHosts-1:0]           req_i,
  input  logic [NumHosts-1:0]           we_i,
  input  logic [NumHosts*4-1:0]         be_i,
  input  logic [NumHosts*AddrWidth-1:0] addr_i,
  input  logic [NumHosts*32-1:0]        wdata_i,
  output logic [NumHosts-1:0]           gnt_o,
  output logic [NumHosts-1:0]           rvalid_o,
  output logic [31:0]                   rdata_o,
  output logic                          ram_req_o,
  output logic                          ram_we_o,
  output logic [3:0]                    ram_be_o,
  output logic [AddrWidth-1:0]          ram_addr_o,
  output logic [31:0]                   ram_wdata_o,
  input  logic                          ram_rvalid_i,
  input  logic [31:0]                   ram_rdata_i
);

  localparam int IdxW = $clog2(NumHosts);

  logic [IdxW-1:0] prio_q, resp_idx_q;
  logic            pend_q;
  logic [IdxW-1:0] winner, idx, next_prio;
  logic            any_req;

  assign any_req = |req_i;

  // Scan from the highest offset down so the lowest offset from prio_q wins.
  always_comb begin
    winner = '0;
    idx    = '0;
    for (int k = NumHosts - 1; k >= 0; k--) begin
      if (RoundRobin) idx = IdxW'((int'(prio_q) + k) % NumHosts);
      else            idx = IdxW'(k);
      if (req_i[idx]) winner = idx;
    end
  end

  assign next_prio = (winner == IdxW'(NumHosts - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < NumHosts; i++) begin
      gnt_o[i] = any_req && (winner == IdxW'(i));
    end
  end

  always_comb begin
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    for (int i = 0; i < NumHosts; i++) begin
      if (gnt_o[i]) begin
        ram_we_o    = we_i[i];
        ram_be_o    = be_i[4*i +: 4];
        ram_addr_o  = addr_i[AddrWidth*i +: AddrWidth];
        ram_wdata_o = wdata_i[32*i +: 32];
      end
    end
  end

  assign ram_req_o = any_req;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q     <= '0;
      pend_q     <= 1'b0;
      resp_idx_q <= '0;
    end else if (any_req) begin
      pend_q     <= 1'b1;
      resp_idx_q <= winner;
      if (RoundRobin) prio_q <= next_prio;
    end else begin
      pend_q <= 1'b0;
    end
  end

  always_comb begin
    rvalid_o = '0;
    for (int i = 0; i < NumHosts; i++) begin
      rvalid_o[i] = ram_rvalid_i & pend_q & (resp_idx_q == IdxW'(i));
    end
  end

  assign rdata_o = ram_rdata_i;

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
  a_gnt_req:    assert property (@(posedge clk_i) disable iff (!rst_ni) (gnt_o & ~req_i) == '0);
  // A response without an outstanding grant means the RAM side is out of step.
  a_rvalid_pend: assert property (@(posedge clk_i) disable iff (!rst_ni) ram_rvalid_i |-> pend_q);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed vector bench for ram_port_arbiter.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req2 = '0, we2 = '0;
  logic [7:0]  be2 = '0;
  logic [63:0] addr2 = '0, wdata2 = '0;
  logic        rvalid2 = 1'b0;
  logic [31:0] rdata2 = '0;

  logic [1:0]  g_rr2, v_rr2, g_fp2, v_fp2;
  logic [31:0] rd_rr2, rd_fp2, raddr_rr2, raddr_fp2, rwd_rr2, rwd_fp2;
  logic        rreq_rr2, rreq_fp2, rwe_rr2, rwe_fp2;
  logic [3:0]  rbe_rr2, rbe_fp2;

  logic [2:0]  req3 = '0, we3 = '0;
  logic [11:0] be3 = 12'hFFF;
  logic [95:0] addr3 = {32'h38, 32'h34, 32'h30};
  logic [95:0] wdata3 = '0;
  logic        rvalid3 = 1'b0;
  logic [31:0] rdata3 = 32'hC0DE0003;
  logic [2:0]  g3, v3;
  logic [31:0] rd3, raddr3, rwd3;
  logic        rreq3, rwe3;
  logic [3:0]  rbe3;

  ram_port_arbiter #(.NumHosts(2), .RoundRobin(1'b1), .AddrWidth(32)) dut_rr2 (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req2), .we_i(we2), .be_i(be2), .addr_i(addr2),
    .wdata_i(wdata2), .gnt_o(g_rr2), .rvalid_o(v_rr2), .rdata_o(rd_rr2), .ram_req_o(rreq_rr2),
    .ram_we_o(rwe_rr2), .ram_be_o(rbe_rr2), .ram_addr_o(raddr_rr2), .ram_wdata_o(rwd_rr2),
    .ram_rvalid_i(rvalid2), .ram_rdata_i(rdata2));

  ram_port_arbiter #(.NumHosts(2), .RoundRobin(1'b0), .AddrWidth(32)) dut_fp2 (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req2), .we_i(we2), .be_i(be2), .addr_i(addr2),
    .wdata_i(wdata2), .gnt_o(g_fp2), .rvalid_o(v_fp2), .rdata_o(rd_fp2), .ram_req_o(rreq_fp2),
    .ram_we_o(rwe_fp2), .ram_be_o(rbe_fp2), .ram_addr_o(raddr_fp2), .ram_wdata_o(rwd_fp2),
    .ram_rvalid_i(rvalid2), .ram_rdata_i(rdata2));

  ram_port_arbiter #(.NumHosts(3), .RoundRobin(1'b1), .AddrWidth(32)) dut_rr3 (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req3), .we_i(we3), .be_i(be3), .addr_i(addr3),
    .wdata_i(wdata3), .gnt_o(g3), .rvalid_o(v3), .rdata_o(rd3), .ram_req_o(rreq3),
    .ram_we_o(rwe3), .ram_be_o(rbe3), .ram_addr_o(raddr3), .ram_wdata_o(rwd3),
    .ram_rvalid_i(rvalid3), .ram_rdata_i(rdata3));

  // RAM model behind the round-robin 2-host port: 1-cycle latency, byte-enabled writes.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    rvalid2 <= rreq_rr2;
    rvalid3 <= rreq3;
    if (rreq_rr2) begin
      if (rwe_rr2) begin
        for (int b = 0; b < 4; b++)
          if (rbe_rr2[b]) mem[raddr_rr2[7:2]][8*b +: 8] <= rwd_rr2[8*b +: 8];
      end else begin
        rdata2 <= mem[raddr_rr2[7:2]];
      end
    end
  end

  typedef struct {
    logic [1:0]  req, we;
    logic [7:0]  be;
    logic [31:0] a0, a1, wd1;
    logic [1:0]  g_rr, g_fp, v_rr, v_fp;
    logic [31:0] e_addr;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic        chk_rd;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs [15];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA0000000 | i;
    //          req    we     be     a0     a1     wd1            g_rr   g_fp   v_rr   v_fp   addr   we    be    wd             chk   rdata
    vecs[0]  = '{2'b00, 2'b00, 8'hFF, 32'h10, 32'h14, 32'h0,        2'b00, 2'b00, 2'b00, 2'b00, 32'h0,  1'b0, 4'h0, 32'h0,        1'b0, 32'h0};
    vecs[1]  = '{2'b01, 2'b00, 8'hFF, 32'h10, 32'h14, 32'h0,        2'b01, 2'b01, 2'b00, 2'b00, 32'h10, 1'b0, 4'hF, 32'h0,        1'b0, 32'h0};
    vecs[2]  = '{2'b00, 2'b00, 8'hFF, 32'h10, 32'h14, 32'h0,        2'b00, 2'b00, 2'b01, 2'b01, 32'h0,  1'b0, 4'h0, 32'h0,        1'b1, 32'hA0000004};
    vecs[3]  = '{2'b10, 2'b00, 8'hFF, 32'h10, 32'h14, 32'h0,        2'b10, 2'b10, 2'b00, 2'b00, 32'h14, 1'b0, 4'hF, 32'h0,        1'b0, 32'h0};
    vecs[4]  = '{2'b11, 2'b00, 8'hFF, 32'h10, 32'h14, 32'h0,        2'b01, 2'b01, 2'b10, 2'b10, 32'h10, 1'b0, 4'hF, 32'h0,        1'b1, 32'hA0000005};
    vecs[5]  = '{2'b11, 2'b00, 8'hFF, 32'h10, 32'h14, 32'h0,        2'b10, 2'b01, 2'b01, 2'b01, 32'h14, 1'b0, 4'hF, 32'h0,        1'b1, 32'hA0000004};
    vecs[6]  = '{2'b11, 2'b00, 8'hFF, 32'h10, 32'h14, 32'h0,        2'b01, 2'b01, 2'b10, 2'b01, 32'h10, 1'b0, 4'hF, 32'h0,        1'b1, 32'hA0000005};
    vecs[7]  = '{2'b11, 2'b00, 8'hFF, 32'h10, 32'h14, 32'h0,        2'b10, 2'b01, 2'b01, 2'b01, 32'h14, 1'b0, 4'hF, 32'h0,        1'b1, 32'hA0000004};
    vecs[8]  = '{2'b11, 2'b00, 8'hFF, 32'h10, 32'h14, 32'h0,        2'b01, 2'b01, 2'b10, 2'b01, 32'h10, 1'b0, 4'hF, 32'h0,        1'b1, 32'hA0000005};
    vecs[9]  = '{2'b11, 2'b00, 8'hFF, 32'h10, 32'h14, 32'h0,        2'b10, 2'b01, 2'b01, 2'b01, 32'h14, 1'b0, 4'hF, 32'h0,        1'b1, 32'hA0000004};
    vecs[10] = '{2'b10, 2'b00, 8'hFF, 32'h10, 32'h14, 32'h0,        2'b10, 2'b10, 2'b10, 2'b01, 32'h14, 1'b0, 4'hF, 32'h0,        1'b1, 32'hA0000005};
    vecs[11] = '{2'b00, 2'b00, 8'hFF, 32'h10, 32'h14, 32'h0,        2'b00, 2'b00, 2'b10, 2'b10, 32'h0,  1'b0, 4'h0, 32'h0,        1'b1, 32'hA0000005};
    vecs[12] = '{2'b10, 2'b10, 8'h3F, 32'h10, 32'h20, 32'hDEADBEEF, 2'b10, 2'b10, 2'b00, 2'b00, 32'h20, 1'b1, 4'h3, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[13] = '{2'b01, 2'b00, 8'hFF, 32'h20, 32'h20, 32'hDEADBEEF, 2'b01, 2'b01, 2'b10, 2'b10, 32'h20, 1'b0, 4'hF, 32'h0,        1'b0, 32'h0};
    vecs[14] = '{2'b00, 2'b00, 8'hFF, 32'h10, 32'h14, 32'h0,        2'b00, 2'b00, 2'b01, 2'b01, 32'h0,  1'b0, 4'h0, 32'h0,        1'b1, 32'hA000BEEF};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      req2   = vecs[i].req;
      we2    = vecs[i].we;
      be2    = vecs[i].be;
      addr2  = {vecs[i].a1, vecs[i].a0};
      wdata2 = {vecs[i].wd1, 32'h0};
      #1;
      chk($sformatf("v%0d gnt_rr", i), 32'(g_rr2), 32'(vecs[i].g_rr));
      chk($sformatf("v%0d gnt_fp", i), 32'(g_fp2), 32'(vecs[i].g_fp));
      chk($sformatf("v%0d rvalid_rr", i), 32'(v_rr2), 32'(vecs[i].v_rr));
      chk($sformatf("v%0d rvalid_fp", i), 32'(v_fp2), 32'(vecs[i].v_fp));
      chk($sformatf("v%0d ram_req", i), 32'(rreq_rr2), 32'(vecs[i].req != 2'b00));
      chk($sformatf("v%0d ram_addr", i), raddr_rr2, vecs[i].e_addr);
      chk($sformatf("v%0d ram_we", i), 32'(rwe_rr2), 32'(vecs[i].e_we));
      chk($sformatf("v%0d ram_be", i), 32'(rbe_rr2), 32'(vecs[i].e_be));
      chk($sformatf("v%0d ram_wdata", i), rwd_rr2, vecs[i].e_wd);
      if (vecs[i].chk_rd) chk($sformatf("v%0d rdata", i), rd_rr2, vecs[i].e_rd);
    end

    // Three hosts: drive prio_q to 2, then host0 must win by wrapping.
    @(negedge clk); req2 = '0; req3 = 3'b010; #1;
    chk("n3 gnt host1", 32'(g3), 32'h2);
    @(negedge clk); req3 = 3'b011; #1;
    chk("n3 gnt wrap", 32'(g3), 32'h1);
    chk("n3 rvalid host1", 32'(v3), 32'h2);
    chk("n3 ram_addr", raddr3, 32'h30);
    chk("n3 rdata", rd3, 32'hC0DE0003);
    @(negedge clk); req3 = 3'b111; #1;
    chk("n3 gnt prio1", 32'(g3), 32'h2);
    chk("n3 rvalid host0", 32'(v3), 32'h1);
    @(negedge clk); req3 = 3'b000; #1;
    chk("n3 gnt idle", 32'(g3), 32'h0);
    chk("n3 rvalid host1 again", 32'(v3), 32'h2);

    // Reset while a response is in flight.
    @(negedge clk); req2 = 2'b10; req3 = 3'b001; #1;
    chk("rst gnt_rr2", 32'(g_rr2), 32'h2);
    chk("rst gnt3", 32'(g3), 32'h1);
    @(posedge clk); #1;
    chk("rst inflight rr2", 32'(v_rr2), 32'h2);
    chk("rst inflight n3", 32'(v3), 32'h1);
    rst_ni = 1'b0; req2 = '0; req3 = '0; #1;
    chk("rst rvalid_rr2", 32'(v_rr2), 32'h0);
    chk("rst rvalid_fp2", 32'(v_fp2), 32'h0);
    chk("rst rvalid3", 32'(v3), 32'h0);
    @(posedge clk);
    @(negedge clk); rst_ni = 1'b1; #1;
    chk("post rst rvalid_rr2", 32'(v_rr2), 32'h0);
    chk("post rst rvalid3", 32'(v3), 32'h0);
    req2 = 2'b11; req3 = 3'b111; #1;
    chk("post rst gnt_rr2", 32'(g_rr2), 32'h1);
    chk("post rst gnt3 prio0", 32'(g3), 32'h1);
    @(negedge clk); req2 = '0; req3 = '0; #1;
    chk("post rst rvalid_rr2 resp", 32'(v_rr2), 32'h1);
    chk("post rst rvalid3 resp", 32'(v3), 32'h1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
